// File: rtl/adder_rr_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
package adder_rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Two's complement overflow: operands agree in sign, sum does not.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, searching upward and wrapping to index 0.
module rr_arbiter
    import adder_rr_sched_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int IdW    = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdW-1:0]    gnt_idx_o,
    output logic              gnt_any_o
);

    // Scan NumReq positions starting at the pointer; the first hit wins.
    always_comb begin
        int w_idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        w_idx     = 0;
        for (int i = 0; i < NumReq; i++) begin
            w_idx = (int'(ptr_i) + i) % NumReq;
            if (!gnt_any_o && req_i[IdW'(w_idx)]) begin
                gnt_any_o              = 1'b1;
                gnt_idx_o              = IdW'(w_idx);
                gnt_o[IdW'(w_idx)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one output-registered signed adder among
// NumReq requesters. One operation every three cycles at best:
// accept (IDLE), add (ADD), present result (RESP).
module adder_rr_sched
    import adder_rr_sched_pkg::*;
#(
    parameter  int Width  = 32,
    parameter  int NumReq = 4,
    localparam int IdW    = $clog2(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq*Width-1:0] req_a_i,
    input  logic [NumReq*Width-1:0] req_b_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [Width-1:0]        res_sum_o,
    output logic                    res_ovf_o,
    output logic [IdW-1:0]          res_id_o
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IdW-1:0]     r_ptr;
    logic [Width-1:0]   r_a;
    logic [Width-1:0]   r_b;
    logic [IdW-1:0]     r_id;
    logic [Width-1:0]   r_sum;
    logic               r_ovf;

    logic [NumReq-1:0]  w_gnt;
    logic [IdW-1:0]     w_gnt_idx;
    logic               w_gnt_any;
    logic               w_accept;
    logic [IdW-1:0]     w_ptr_nxt;
    logic [Width-1:0]   w_sum;

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (r_ptr),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx),
        .gnt_any_o (w_gnt_any)
    );

    assign w_sum     = r_a + r_b;
    assign w_ptr_nxt = (w_gnt_idx == IdW'(NumReq - 1)) ? '0 : w_gnt_idx + IdW'(1);

    // Next-state and handshake outputs; ready is only offered while idle.
    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        res_valid_o = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_any) begin
                    req_ready_o = w_gnt;
                    w_accept    = 1'b1;
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture operands, requester ID and advance the pointer on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_id  <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
            r_a   <= req_a_i[int'(w_gnt_idx)*Width +: Width];
            r_b   <= req_b_i[int'(w_gnt_idx)*Width +: Width];
            r_id  <= w_gnt_idx;
        end
    end

    // Output-registered adder; the result holds until the next ADD cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == ADD) begin
            r_sum <= w_sum;
            r_ovf <= signed_ovf(r_a[Width-1], r_b[Width-1], w_sum[Width-1]);
        end
    end

    assign res_sum_o = r_sum;
    assign res_ovf_o = r_ovf;
    assign res_id_o  = r_id;

endmodule
